logic_bist_ctrl: RTL and testbench
==================================

Name: logic_bist_ctrl

Overview:
Parametrised built-in self-test controller for the gate/switch-level cell library (nand/and/xor/inverter models). It drives an N_IN-bit stimulus bus into a combinational cell under test, either as an exhaustive binary count or as a pseudo-random LFSR sequence. Each cell response is folded into a MISR signature, which is compared against a golden value. It replaces hand-written incrementing-stimulus benches with a reusable, synthesisable sequential block that sits between a test sequencer and any cell instance.

Parameters:
N_IN, 3, stimulus width (2..16)
N_OUT, 1, response width from the cell under test (1..SIG_W)
SIG_W, 16, MISR signature width (8..32)
MISR_POLY, 16'h1021, MISR feedback polynomial (SIG_W bits)
LFSR_POLY, 3'b110, Galois LFSR feedback mask (N_IN bits; must be maximal-length)
SETTLE, 1, extra cycles each pattern is held before its response is sampled (0..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin run; sampled only in IDLE or DONE
abort  input  1  terminate run, return to IDLE
mode  input  1  0 = exhaustive count, 1 = LFSR; sampled with start
seed  input  N_IN  LFSR start state; sampled with start
pat_count  input  N_IN  LFSR pattern count; 0 means 2^N_IN-1
golden  input  SIG_W  expected signature
resp  input  N_OUT  cell-under-test response
pattern  output  N_IN  stimulus to the cell under test
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at run completion
signature  output  SIG_W  MISR value
pass  output  1  (signature == golden), valid from done until the next start

Behaviour:
- Reset (async, rst_n=0): state IDLE. pattern, busy, done, signature and pass are all 0. Reset mid-run aborts the run immediately.
- States: IDLE, APPLY, DONE.
- IDLE/DONE + start=1:
  - Go to APPLY on the next edge.
  - Signature, pattern counter and hold counter are cleared.
  - pass is cleared.
  - mode, seed and pat_count are latched.
- start while in APPLY is ignored.
- Stimulus source:
  - mode 0: pattern = 0, 1, ..., 2^N_IN-1. Total patterns = 2^N_IN.
  - mode 1: first pattern = latched seed, with seed 0 replaced by 1.
  - mode 1 next state: if lsb=1, (s>>1)^LFSR_POLY; else s>>1.
  - mode 1 total patterns = pat_count, or 2^N_IN-1 when pat_count is 0.
- APPLY timing:
  - Each pattern is held on the pattern port for SETTLE+1 cycles.
  - resp is sampled at the rising edge ending the final hold cycle.
  - At that same edge: sig <= (sig<<1) ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ zero_ext(resp).
  - The pattern advances at that same edge.
  - busy = 1 throughout APPLY.
- Completion:
  - After the last capture, go to DONE.
  - done = 1 for exactly one cycle (the first DONE cycle); busy = 0.
  - signature and pass are held in DONE until the next start.
  - pattern holds its last applied value in DONE.
- Run length: busy is high for exactly total_patterns × (SETTLE+1) cycles.
- abort=1 in APPLY:
  - Go to IDLE on the next edge; done is not pulsed.
  - signature and pass are cleared; pattern returns to 0.
  - abort has priority over the capture on that edge.
- abort in IDLE or DONE has no effect.
- start and abort asserted together in IDLE/DONE: start wins.
- Width rules:
  - Counters are sized to N_IN+1 bits, so 2^N_IN does not wrap.
  - The resp fold uses the low N_OUT bits of the signature.
- Elaboration errors: N_OUT > SIG_W, or N_IN < 2.

Test Plan:
1. Defaults, mode 0, resp = NAND3(pattern) (1,1,1,1,1,1,1,0) -> pattern 0..7, busy high 16 cycles, done pulse, signature 16'h00FE; golden=16'h00FE gives pass=1, golden=16'h00FF gives pass=0.
2. mode 1, seed 3'b001, pat_count 0 -> patterns 001,110,011,111,101,100,010 (7 patterns), busy 14 cycles; seed 3'b000 -> first pattern 001.
3. SETTLE=0, mode 0, resp tied 1 -> signature 16'h00FF after 8 cycles of busy; each pattern is visible for exactly 1 cycle.
4. abort at cycle 5 of a mode-0 run -> IDLE next cycle, no done, signature 0, pattern 0; start at cycle 5 of a run has no effect.
5. rst_n low mid-run (asynchronous, between edges) -> all outputs 0 immediately; a subsequent start reproduces signature 16'h00FE.
6. Back-to-back: start asserted in the done cycle -> new run begins and pass clears; N_IN=4, N_OUT=2 instance completes with busy = 32 cycles.

Source files
------------

// File: rtl/logic_bist_ctrl.sv
// Logic BIST controller: drives exhaustive or LFSR stimulus into a combinational
// cell under test and compacts its responses into a MISR signature.
module logic_bist_ctrl #(
    parameter int              N_IN      = 3,
    parameter int              N_OUT     = 1,
    parameter int              SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [N_IN-1:0]  LFSR_POLY = 3'b110,
    parameter int              SETTLE    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [N_IN-1:0]  seed,
    input  logic [N_IN-1:0]  pat_count,
    input  logic [SIG_W-1:0] golden,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  pattern,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             pass
);

    // state | meaning
    // IDLE  | waiting for start, outputs cleared
    // APPLY | holding patterns and folding responses into the MISR
    // DONE  | run finished, signature and pass held until next start

    generate
        if (N_OUT > SIG_W) begin : g_err_nout
            $error("logic_bist_ctrl: N_OUT must not exceed SIG_W");
        end
        if (N_IN < 2) begin : g_err_nin
            $error("logic_bist_ctrl: N_IN must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    localparam logic [N_IN:0] ALL_PATS  = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0] LFSR_PATS = {1'b0, {N_IN{1'b1}}};
    localparam logic [3:0]    HOLD_LAST = 4'(SETTLE);

    state_t           state;
    logic [N_IN:0]    cnt;
    logic [N_IN:0]    total;
    logic [3:0]       hold;
    logic             lmode;
    logic [SIG_W-1:0] resp_ext;
    logic [SIG_W-1:0] sig_nxt;
    logic [N_IN-1:0]  pat_nxt;
    logic [N_IN-1:0]  start_pat;
    logic [N_IN:0]    start_total;
    logic             last;

    always_comb begin
        resp_ext = '0;
        resp_ext[N_OUT-1:0] = resp;
        sig_nxt = {signature[SIG_W-2:0], 1'b0}
                ^ (signature[SIG_W-1] ? MISR_POLY : '0)
                ^ resp_ext;
        if (lmode)
            pat_nxt = pattern[0] ? ((pattern >> 1) ^ LFSR_POLY) : (pattern >> 1);
        else
            pat_nxt = pattern + 1'b1;
        last = (cnt + 1'b1) == total;
        // an all-zero seed would lock the LFSR, so it is promoted to 1
        if (mode) begin
            start_pat   = (seed == '0) ? N_IN'(1) : seed;
            start_total = (pat_count == '0) ? LFSR_PATS : {1'b0, pat_count};
        end else begin
            start_pat   = '0;
            start_total = ALL_PATS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pattern   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
            pass      <= 1'b0;
            cnt       <= '0;
            total     <= '0;
            hold      <= '0;
            lmode     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (state == DONE)
                        pass <= (signature == golden);
                    if (start) begin
                        state     <= APPLY;
                        busy      <= 1'b1;
                        signature <= '0;
                        pass      <= 1'b0;
                        cnt       <= '0;
                        hold      <= '0;
                        lmode     <= mode;
                        total     <= start_total;
                        pattern   <= start_pat;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        signature <= '0;
                        pass      <= 1'b0;
                        pattern   <= '0;
                    end else if (hold == HOLD_LAST) begin
                        signature <= sig_nxt;
                        hold      <= '0;
                        cnt       <= cnt + 1'b1;
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_nxt == golden);
                        end else begin
                            pattern <= pat_nxt;
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_bist_ctrl.sv
// Bench for logic_bist_ctrl: three configurations, directed plus random runs
// checked against a pattern-list / signature reference model.
module tb_logic_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : g_cfg
            localparam int NI   = (g == 2) ? 4 : 3;
            localparam int NO   = (g == 2) ? 2 : 1;
            localparam int S    = (g == 1) ? 0 : 1;
            localparam int NP   = 1 << NI;
            localparam int LPI  = (g == 2) ? 12 : 6;
            localparam logic [NI-1:0] LP = NI'(LPI);

            logic          rst_n, start, abort, mode;
            logic [NI-1:0] seed, pat_count, pattern;
            logic [15:0]   golden, signature;
            logic [NO-1:0] resp;
            logic          busy, done, pass;
            logic [NO-1:0] tt [NP];
            bit            fin = 1'b0;

            assign resp = tt[pattern];

            logic_bist_ctrl #(
                .N_IN(NI), .N_OUT(NO), .SIG_W(16), .MISR_POLY(16'h1021),
                .LFSR_POLY(LP), .SETTLE(S)
            ) dut (
                .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
                .mode(mode), .seed(seed), .pat_count(pat_count), .golden(golden),
                .resp(resp), .pattern(pattern), .busy(busy), .done(done),
                .signature(signature), .pass(pass)
            );

            function automatic string tg(input string s);
                return $sformatf("cfg%0d %s", g, s);
            endfunction

            task automatic check_zero(input string s);
                check_val(tg({s, " pattern"}), 32'(pattern), 0);
                check_val(tg({s, " busy"}), 32'(busy), 0);
                check_val(tg({s, " done"}), 32'(done), 0);
                check_val(tg({s, " signature"}), 32'(signature), 0);
                check_val(tg({s, " pass"}), 32'(pass), 0);
            endtask

            // gsel: 0 golden = expected, 1 golden = expected^1, 2 random golden
            task automatic run(input bit m, input int sd, input int pc, input int abort_at,
                               input int rst_at, input bit chain, input int gsel, input int const_sig);
                int q[$];
                int s, n, esig, eb, gv;
                if (!m) begin
                    for (int i = 0; i < NP; i++) q.push_back(i);
                end else begin
                    n = (pc == 0) ? NP - 1 : pc;
                    s = (sd == 0) ? 1 : sd;
                    for (int i = 0; i < n; i++) begin
                        q.push_back(s);
                        s = (s & 1) ? ((s >> 1) ^ LPI) : (s >> 1);
                    end
                end
                esig = 0;
                foreach (q[i])
                    esig = ((esig << 1) & 'hFFFF) ^ ((esig & 'h8000) ? 'h1021 : 0) ^ int'(tt[q[i]]);
                gv = (gsel == 0) ? esig : (gsel == 1) ? (esig ^ 1) : int'($urandom_range(0, 'hFFFF));
                eb = q.size() * (S + 1);

                start = 1'b1; mode = m; seed = NI'(sd); pat_count = NI'(pc); golden = 16'(gv);
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                for (int k = 0; k <= eb + 1; k++) begin
                    if (k < eb) begin
                        check_val(tg("busy run"), 32'(busy), 1);
                        check_val(tg("pattern run"), 32'(pattern), 32'(q[k / (S + 1)]));
                        check_val(tg("done run"), 32'(done), 0);
                        if (k == 0) begin
                            check_val(tg("signature cleared"), 32'(signature), 0);
                            check_val(tg("pass cleared"), 32'(pass), 0);
                        end
                        start = ($urandom_range(0, 3) == 0);
                        if (k == abort_at) begin
                            start = 1'b0;
                            abort = 1'b1;
                            @(negedge clk);
                            abort = 1'b0;
                            check_zero("after abort");
                            return;
                        end
                        if (k == rst_at) begin
                            start = 1'b0;
                            #2 rst_n = 1'b0;
                            #1 check_zero("async reset");
                            #1 rst_n = 1'b1;
                            @(negedge clk);
                            check_val(tg("busy after reset"), 32'(busy), 0);
                            return;
                        end
                    end else if (k == eb) begin
                        start = 1'b0;
                        check_val(tg("busy end"), 32'(busy), 0);
                        check_val(tg("done pulse"), 32'(done), 1);
                        check_val(tg("signature"), 32'(signature), 32'(esig));
                        check_val(tg("pass"), 32'(pass), 32'(esig == gv));
                        check_val(tg("pattern hold"), 32'(pattern), 32'(q[q.size() - 1]));
                        if (const_sig >= 0)
                            check_val(tg("signature const"), 32'(signature), 32'(const_sig));
                        if (chain) return;
                        abort = 1'($urandom_range(0, 1));
                    end else begin
                        abort = 1'b0;
                        check_val(tg("done one cycle"), 32'(done), 0);
                        check_val(tg("busy done"), 32'(busy), 0);
                        check_val(tg("signature held"), 32'(signature), 32'(esig));
                        check_val(tg("pass held"), 32'(pass), 32'(esig == gv));
                        check_val(tg("pattern held"), 32'(pattern), 32'(q[q.size() - 1]));
                    end
                    @(negedge clk);
                end
            endtask

            initial begin
                rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
                seed = '0; pat_count = '0; golden = '0;
                for (int i = 0; i < NP; i++) tt[i] = '0;
                #12 check_zero("reset");
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                if (g == 0) begin
                    for (int i = 0; i < NP; i++) tt[i] = NO'(i != 7);
                    run(0, 0, 0, -1, -1, 0, 0, 'h00FE);
                    run(0, 0, 0, -1, -1, 0, 1, 'h00FE);
                    run(1, 1, 0, -1, -1, 0, 2, -1);
                    run(1, 0, 0, -1, -1, 0, 0, -1);
                    run(0, 0, 0, 5, -1, 0, 0, -1);
                    run(0, 0, 0, -1, 7, 0, 0, -1);
                    run(0, 0, 0, -1, -1, 0, 0, 'h00FE);
                end else if (g == 1) begin
                    for (int i = 0; i < NP; i++) tt[i] = '1;
                    run(0, 0, 0, -1, -1, 0, 0, 'h00FF);
                end else begin
                    for (int i = 0; i < NP; i++) tt[i] = NO'($urandom);
                    run(0, 0, 0, -1, -1, 1, 0, -1);
                    run(0, 0, 0, -1, -1, 0, 1, -1);
                end
                for (int r = 0; r < 25; r++) begin
                    for (int i = 0; i < NP; i++) tt[i] = NO'($urandom);
                    run(1'($urandom_range(0, 1)), int'($urandom_range(0, NP - 1)),
                        int'($urandom_range(0, NP - 1)),
                        ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1,
                        -1, (r < 24) && ($urandom_range(0, 2) == 0),
                        int'($urandom_range(0, 2)), -1);
                end
                fin = 1'b1;
            end
        end
    endgenerate

    initial begin
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin))
            check_val("run timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
